puu_div_sched: RTL and testbench

PUU_DIV_SCHED -- requirements
Module: puu_div_sched

---
 rtl/puu_pkg.sv | 22 ++
 rtl/puu_div_sched_if.sv | 32 +++
 rtl/puu_out_reasm.sv | 58 +++++
 rtl/puu_div_sched.sv | 109 ++++++++++
 tb/tb_puu_div_sched.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puu_pkg.sv
// Shared constants, FSM encoding and helpers for the shared-divider scheduler.
package puu_pkg;

    localparam int unsigned DivisorDefault = 45;
    localparam int unsigned SampleW        = 12;
    localparam int unsigned DividendW      = 16;
    localparam int unsigned DivisorW       = 8;
    localparam int unsigned DoutW          = 24;
    localparam int unsigned QuotMsb        = 19;
    localparam int unsigned QuotLsb        = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssueRe,
        StIssueIm
    } sched_state_e;

    function automatic logic [DividendW-1:0] sext_sample(input logic [SampleW-1:0] s);
        return {{(DividendW - SampleW){s[SampleW-1]}}, s};
    endfunction

endpackage

// File: rtl/puu_div_sched_if.sv
// Sample-in, divider-core and result-out signal bundle of the scheduler.
interface puu_div_sched_if;
    import puu_pkg::*;

    logic [SampleW-1:0]   di_re;
    logic [SampleW-1:0]   di_im;
    logic                 di_vld;
    logic                 di_rdy;
    logic [DividendW-1:0] div_dividend_tdata;
    logic                 div_dividend_tvalid;
    logic [DivisorW-1:0]  div_divisor_tdata;
    logic                 div_divisor_tvalid;
    logic [DoutW-1:0]     div_dout_tdata;
    logic                 div_dout_tvalid;
    logic [SampleW-1:0]   do_re;
    logic [SampleW-1:0]   do_im;
    logic                 do_vld;
    logic                 err;

    modport slave (
        input  di_re, di_im, di_vld, div_dout_tdata, div_dout_tvalid,
        output di_rdy, div_dividend_tdata, div_dividend_tvalid, div_divisor_tdata,
               div_divisor_tvalid, do_re, do_im, do_vld, err
    );

    modport master (
        output di_re, di_im, di_vld, div_dout_tdata, div_dout_tvalid,
        input  di_rdy, div_dividend_tdata, div_dividend_tvalid, div_divisor_tdata,
               div_divisor_tvalid, do_re, do_im, do_vld, err
    );

endinterface

// File: rtl/puu_out_reasm.sv
// Pairs consecutive divider results (real then imaginary) into one output sample.
module puu_out_reasm
    import puu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               res_vld_i,
    input  logic [SampleW-1:0] quot_i,
    output logic [SampleW-1:0] do_re_o,
    output logic [SampleW-1:0] do_im_o,
    output logic               do_vld_o
);

    logic               phase_q, phase_d;
    logic [SampleW-1:0] held_re_q, held_re_d;
    logic [SampleW-1:0] do_re_q, do_re_d;
    logic [SampleW-1:0] do_im_q, do_im_d;
    logic               do_vld_q, do_vld_d;

    always_comb begin
        phase_d   = phase_q;
        held_re_d = held_re_q;
        do_re_d   = do_re_q;
        do_im_d   = do_im_q;
        do_vld_d  = 1'b0;
        if (res_vld_i) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                held_re_d = quot_i;
            end else begin
                do_re_d  = {held_re_q[SampleW-2:0], 1'b0};
                do_im_d  = {quot_i[SampleW-2:0], 1'b0};
                do_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= 1'b0;
            held_re_q <= '0;
            do_re_q   <= '0;
            do_im_q   <= '0;
            do_vld_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            held_re_q <= held_re_d;
            do_re_q   <= do_re_d;
            do_im_q   <= do_im_d;
            do_vld_q  <= do_vld_d;
        end
    end

    assign do_re_o  = do_re_q;
    assign do_im_o  = do_im_q;
    assign do_vld_o = do_vld_q;

endmodule

// File: rtl/puu_div_sched.sv
// Time-shares one divider core between the real and imaginary part of each
// sample, tracks results in flight and reassembles the quotient pair.
module puu_div_sched
    import puu_pkg::*;
#(
    parameter int unsigned DIVISOR = DivisorDefault,
    parameter int unsigned DIV_LAT = 20,
    parameter int unsigned MAX_OUT = 32
) (
    input logic            clk,
    input logic            rst,
    puu_div_sched_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    if (MAX_OUT < DIV_LAT + 2) begin : g_cfg_check
        $error("MAX_OUT must be at least DIV_LAT + 2");
    end

    sched_state_e         state_q, state_d;
    logic [SampleW-1:0]   re_q, re_d;
    logic [SampleW-1:0]   im_q, im_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 issue, rdy, accept, ret_vld, ret_bad;
    logic [DividendW-1:0] dividend;
    logic                 unused_dout;

    always_comb begin
        issue   = (state_q != StIdle);
        ret_vld = bus.div_dout_tvalid && (cnt_q != '0);
        ret_bad = bus.div_dout_tvalid && (cnt_q == '0);
        // A sample costs two slots; include the dividend leaving in ISSUE_IM.
        rdy     = !rst && (state_q != StIssueRe) &&
                  ((cnt_q + CntW'(state_q == StIssueIm)) <= CntW'(MAX_OUT - 2));
        accept  = bus.di_vld && rdy;

        state_d = state_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            StIdle, StIssueIm: begin
                if (accept) begin
                    state_d = StIssueRe;
                    re_d    = bus.di_re;
                    im_d    = bus.di_im;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssueRe: state_d = StIssueIm;
            default:   state_d = StIdle;
        endcase

        dividend = '0;
        case (state_q)
            StIssueRe: dividend = sext_sample(re_q);
            StIssueIm: dividend = sext_sample(im_q);
            default:   dividend = '0;
        endcase

        cnt_d = cnt_q;
        if (issue && !ret_vld) begin
            if (cnt_q != CntW'(MAX_OUT)) cnt_d = cnt_q + CntW'(1);
        end else if (!issue && ret_vld) begin
            cnt_d = cnt_q - CntW'(1);
        end
        err_d = err_q | ret_bad | (issue && (cnt_q == CntW'(MAX_OUT)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            re_q    <= '0;
            im_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            im_q    <= im_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.di_rdy              = rdy;
    assign bus.div_dividend_tvalid = issue;
    assign bus.div_divisor_tvalid  = issue;
    assign bus.div_dividend_tdata  = dividend;
    assign bus.div_divisor_tdata   = issue ? DivisorW'(DIVISOR) : '0;
    assign bus.err                 = err_q;

    // Only the integer part of the quotient is used.
    assign unused_dout = ^{bus.div_dout_tdata[DoutW-1:QuotMsb+1],
                           bus.div_dout_tdata[QuotLsb-1:0]};

    puu_out_reasm u_out_reasm (
        .clk      (clk),
        .rst      (rst),
        .res_vld_i(ret_vld),
        .quot_i   (bus.div_dout_tdata[QuotMsb:QuotLsb]),
        .do_re_o  (bus.do_re),
        .do_im_o  (bus.do_im),
        .do_vld_o (bus.do_vld)
    );

endmodule

// File: tb/tb_puu_div_sched.sv
// Bench for puu_div_sched: divider-core model plus quotient reference queue.
module tb_puu_div_sched;
    import puu_pkg::*;

    localparam int DivLat  = 20;
    localparam int MaxOut  = 32;
    localparam int Divisor = 45;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    puu_div_sched_if bus ();

    puu_div_sched #(
        .DIVISOR(Divisor),
        .DIV_LAT(DivLat),
        .MAX_OUT(MaxOut)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct { logic [23:0] d; int due; } div_job_t;
    typedef struct { int re; int im; int due; } exp_t;

    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       acc_cnt = 0;
    int       vld_cnt = 0;
    int       inject_req = 0;
    int       inject_done = 0;
    bit       stall = 1'b0;
    bit       lat_mode = 1'b1;
    div_job_t div_q[$];
    exp_t     exp_q[$];
    div_job_t job;
    exp_t     mon_e;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int s12(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    // Reference: output = 2 * floor(sample / divisor code).
    function automatic int ref_out(input int x);
        int q;
        q = x / Divisor;
        if ((x % Divisor != 0) && (x < 0)) q = q - 1;
        return 2 * q;
    endfunction

    // Divider core: signed quotient with 8 fractional bits, floor rounding.
    function automatic logic [23:0] div_core(input logic [15:0] d, input logic [7:0] dv);
        longint n, q, den;
        den = longint'(dv);
        if (den == 0) return '0;
        n = longint'($signed(d)) * 256;
        q = n / den;
        if ((n % den != 0) && (n < 0)) q = q - 1;
        return q[23:0];
    endfunction

    // Divider model and output monitor, both sampling mid-cycle.
    initial begin
        bus.div_dout_tvalid = 1'b0;
        bus.div_dout_tdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.div_dividend_tvalid) begin
                chk("divisor_tvalid", 32'(bus.div_divisor_tvalid), 1);
                chk("divisor_tdata", 32'(bus.div_divisor_tdata), Divisor);
                div_q.push_back('{d: div_core(bus.div_dividend_tdata, bus.div_divisor_tdata),
                                  due: cyc + DivLat});
            end
            bus.div_dout_tvalid = 1'b0;
            if (inject_req != inject_done) begin
                inject_done++;
                bus.div_dout_tvalid = 1'b1;
                bus.div_dout_tdata  = 24'h05a5a5;
            end else if (!stall && div_q.size() > 0 && div_q[0].due <= cyc) begin
                job = div_q.pop_front();
                bus.div_dout_tvalid = 1'b1;
                bus.div_dout_tdata  = job.d;
            end

            if (rst) begin
                exp_q.delete();
            end else begin
                if (bus.di_vld && bus.di_rdy) begin
                    exp_q.push_back('{re: ref_out(s12(bus.di_re)), im: ref_out(s12(bus.di_im)),
                                      due: cyc + 3 + DivLat});
                    acc_cnt++;
                end
                if (bus.do_vld) begin
                    vld_cnt++;
                    chk("do_vld_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        chk("do_re", s12(bus.do_re), mon_e.re);
                        chk("do_im", s12(bus.do_im), mon_e.im);
                        if (lat_mode) chk("latency", cyc, mon_e.due);
                    end
                end
            end
        end
    end

    task automatic send(input int re, input int im);
        int n = 0;
        bus.di_re  = 12'(re);
        bus.di_im  = 12'(im);
        bus.di_vld = 1'b1;
        @(negedge clk);
        while (!bus.di_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", 32'(n < 200), 1);
        @(posedge clk);
        #1;
        bus.di_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || div_q.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_bound", 32'(n < 1000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, v0, hi;
        bus.di_vld = 1'b0;
        bus.di_re  = '0;
        bus.di_im  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_di_rdy", 32'(bus.di_rdy), 0);
        chk("rst_tvalid", 32'(bus.div_dividend_tvalid), 0);
        chk("rst_tdata", 32'(bus.div_dividend_tdata), 0);
        chk("rst_do_vld", 32'(bus.do_vld), 0);
        chk("rst_do_re", s12(bus.do_re), 0);
        chk("rst_err", 32'(bus.err), 0);
        rst = 1'b0;

        // Single sample, exact latency
        send(450, -225);
        drain();
        chk("single_do_re", s12(bus.do_re), 20);
        chk("single_do_im", s12(bus.do_im), -10);

        // Extremes
        send(2047, -2048);
        drain();
        chk("extreme_do_re", s12(bus.do_re), 90);
        chk("extreme_do_im", s12(bus.do_im), -92);

        // Sustained input: one accept every other cycle
        a0 = acc_cnt;
        v0 = vld_cnt;
        bus.di_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.di_re = 12'($urandom);
            bus.di_im = 12'($urandom);
            @(negedge clk);
            chk("rdy_pattern", 32'(bus.di_rdy), 32'(i % 2 == 0));
            @(posedge clk);
            #1;
        end
        bus.di_vld = 1'b0;
        chk("sustained_accepts", acc_cnt - a0, 50);
        drain();
        chk("sustained_outputs", vld_cnt - v0, 50);

        // Divider output stalled until the in-flight limit is reached
        lat_mode = 1'b0;
        stall = 1'b1;
        a0 = acc_cnt;
        v0 = vld_cnt;
        hi = 0;
        bus.di_vld = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bus.di_re = 12'($urandom);
            bus.di_im = 12'($urandom);
            @(negedge clk);
            if (i >= 40) hi += int'(bus.di_rdy);
            @(posedge clk);
            #1;
        end
        bus.di_vld = 1'b0;
        chk("full_accepts", acc_cnt - a0, MaxOut / 2);
        chk("rdy_while_full", hi, 0);
        chk("err_while_full", 32'(bus.err), 0);
        stall = 1'b0;
        drain();
        chk("full_outputs", vld_cnt - v0, MaxOut / 2);
        chk("err_after_full", 32'(bus.err), 0);
        lat_mode = 1'b1;

        // Result with nothing outstanding
        v0 = vld_cnt;
        inject_req++;
        repeat (5) @(posedge clk);
        #1;
        chk("err_set", 32'(bus.err), 1);
        chk("inject_no_vld", vld_cnt - v0, 0);
        send(-900, 1350);
        drain();
        chk("err_sticky", 32'(bus.err), 1);
        chk("post_inject_outputs", vld_cnt - v0, 1);

        // Reset while issuing the real part
        v0 = vld_cnt;
        bus.di_re  = 12'(100);
        bus.di_im  = 12'(50);
        bus.di_vld = 1'b1;
        @(negedge clk);
        chk("pre_rst_rdy", 32'(bus.di_rdy), 1);
        @(posedge clk);
        #1;
        bus.di_vld = 1'b0;
        chk("issue_re_tvalid", 32'(bus.div_dividend_tvalid), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_tvalid", 32'(bus.div_dividend_tvalid), 0);
        chk("rstmid_div_tvalid", 32'(bus.div_divisor_tvalid), 0);
        chk("rstmid_tdata", 32'(bus.div_dividend_tdata), 0);
        chk("rstmid_divisor", 32'(bus.div_divisor_tdata), 0);
        chk("rstmid_rdy", 32'(bus.di_rdy), 0);
        chk("rstmid_do_vld", 32'(bus.do_vld), 0);
        chk("rstmid_do_re", s12(bus.do_re), 0);
        chk("rstmid_do_im", s12(bus.do_im), 0);
        chk("rstmid_err", 32'(bus.err), 0);
        repeat (DivLat + 5) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.di_re  = 12'(-1000);
        bus.di_im  = 12'(777);
        bus.di_vld = 1'b1;
        @(negedge clk);
        chk("first_accept_after_rst", 32'(bus.di_rdy), 1);
        @(posedge clk);
        #1;
        bus.di_vld = 1'b0;
        drain();
        chk("post_rst_outputs", vld_cnt - v0, 1);
        chk("post_rst_err", 32'(bus.err), 0);

        // Random traffic with random divider stalls
        lat_mode = 1'b0;
        a0 = acc_cnt;
        v0 = vld_cnt;
        for (int i = 0; i < 300; i++) begin
            bus.di_vld = 1'($urandom % 2);
            bus.di_re  = 12'($urandom);
            bus.di_im  = 12'($urandom);
            stall      = (($urandom % 4) == 0);
            @(posedge clk);
            #1;
        end
        bus.di_vld = 1'b0;
        stall = 1'b0;
        drain();
        chk("random_outputs", vld_cnt - v0, acc_cnt - a0);
        chk("random_err", 32'(bus.err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
